// File: rtl/memory_stage_if.sv
// Data-memory port of the M stage: registered request side plus read data / ack return.
interface memory_stage_if #(
  parameter int ADDR_W = 19
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [18:0]       mem_wdata;
  logic              mem_bytemask;
  logic [18:0]       mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_bytemask,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_bytemask,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/memory_stage.sv
// Memory stage of the 19-bit pipeline: req/ack data access with stall, timeout watchdog
// and the M/W pipeline register.
module memory_stage #(
  parameter int ADDR_W  = 19,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 RegWriteM,
  input  logic                 MemWriteM,
  input  logic                 ResultSrcM,
  input  logic [4:0]           RDM,
  input  logic [18:0]          WriteDataM,
  input  logic [18:0]          ALUResultM,
  input  logic                 Cant_ByteM,
  memory_stage_if.master       mem,
  output logic                 StallM,
  output logic                 mem_err,
  output logic                 RegWriteW,
  output logic                 ResultSrcW,
  output logic [4:0]           RDW,
  output logic [18:0]          ALUResultW,
  output logic [18:0]          ReadDataW
);

  localparam logic [7:0] TMO = 8'(TIMEOUT);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state, state_n;
  logic        acc, ack, tmo, done;
  logic [7:0]  cnt;
  logic        lat_rw, lat_rs, lat_byte;
  logic [4:0]  lat_rd;
  logic [18:0] lat_alu;
  logic [18:0] load_data;

  always_comb begin
    acc     = MemWriteM | (ResultSrcM & RegWriteM);
    ack     = (state == BUSY) & mem.mem_ack;
    tmo     = (state == BUSY) & ~mem.mem_ack & (cnt == TMO);
    done    = ack | tmo;
    state_n = state;
    unique case (state)
      IDLE: if (acc)  state_n = BUSY;
      BUSY: if (done) state_n = IDLE;
    endcase
    // Gated by reset so the stall drops immediately even with an access still on the inputs.
    StallM = ~reset & (((state == IDLE) & acc) | ((state == BUSY) & ~done));
  end

  always_comb begin
    load_data = '0;
    if (!tmo && !mem.mem_we)
      load_data = lat_byte ? {11'b0, mem.mem_rdata[7:0]} : mem.mem_rdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem.mem_req      <= 1'b0;
      mem.mem_we       <= 1'b0;
      mem.mem_addr     <= '0;
      mem.mem_wdata    <= '0;
      mem.mem_bytemask <= 1'b0;
      mem_err          <= 1'b0;
      cnt              <= '0;
      lat_rw           <= 1'b0;
      lat_rs           <= 1'b0;
      lat_byte         <= 1'b0;
      lat_rd           <= '0;
      lat_alu          <= '0;
      RegWriteW        <= 1'b0;
      ResultSrcW       <= 1'b0;
      RDW              <= '0;
      ALUResultW       <= '0;
      ReadDataW        <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (acc) begin
            mem.mem_req      <= 1'b1;
            mem.mem_we       <= MemWriteM;
            mem.mem_addr     <= ALUResultM[ADDR_W-1:0];
            mem.mem_wdata    <= WriteDataM;
            mem.mem_bytemask <= Cant_ByteM & MemWriteM;
            lat_rw           <= RegWriteM;
            lat_rs           <= ResultSrcM;
            lat_rd           <= RDM;
            lat_alu          <= ALUResultM;
            lat_byte         <= Cant_ByteM;
            cnt              <= '0;
            RegWriteW        <= 1'b0;
            ResultSrcW       <= 1'b0;
            RDW              <= '0;
            ALUResultW       <= '0;
            ReadDataW        <= '0;
          end else begin
            RegWriteW  <= RegWriteM;
            ResultSrcW <= ResultSrcM;
            RDW        <= RDM;
            ALUResultW <= ALUResultM;
            ReadDataW  <= '0;
          end
        end
        BUSY: begin
          if (done) begin
            mem.mem_req <= 1'b0;
            RegWriteW   <= lat_rw;
            ResultSrcW  <= lat_rs;
            RDW         <= lat_rd;
            ALUResultW  <= lat_alu;
            ReadDataW   <= load_data;
            if (tmo) mem_err <= 1'b1;
          end else begin
            cnt        <= cnt + 8'd1;
            RegWriteW  <= 1'b0;
            ResultSrcW <= 1'b0;
            RDW        <= '0;
            ALUResultW <= '0;
            ReadDataW  <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Randomized scoreboard bench for memory_stage: a driver issues instructions and queues
// expected W results from an array-based memory model; a monitor checks each retirement.
module tb_memory_stage;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        RegWriteM, MemWriteM, ResultSrcM, Cant_ByteM;
  logic [4:0]  RDM;
  logic [18:0] WriteDataM, ALUResultM;
  logic        StallM, mem_err, RegWriteW, ResultSrcW;
  logic [4:0]  RDW;
  logic [18:0] ALUResultW, ReadDataW;

  memory_stage_if #(.ADDR_W(19)) mif ();

  memory_stage #(.ADDR_W(19), .TIMEOUT(TMO)) dut (
    .clk        (clk),
    .reset      (reset),
    .RegWriteM  (RegWriteM),
    .MemWriteM  (MemWriteM),
    .ResultSrcM (ResultSrcM),
    .RDM        (RDM),
    .WriteDataM (WriteDataM),
    .ALUResultM (ALUResultM),
    .Cant_ByteM (Cant_ByteM),
    .mem        (mif.master),
    .StallM     (StallM),
    .mem_err    (mem_err),
    .RegWriteW  (RegWriteW),
    .ResultSrcW (ResultSrcW),
    .RDW        (RDW),
    .ALUResultW (ALUResultW),
    .ReadDataW  (ReadDataW)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rw, rs, err;
    logic [4:0]  rd;
    logic [18:0] alu, rdata;
  } wexp_t;

  typedef struct {
    logic        we, bm;
    logic [18:0] addr, wdata;
  } req_t;

  wexp_t       exp_q[$];
  req_t        req_q[$];
  logic [18:0] ref_mem [int];
  logic [18:0] resp_mem [int];

  int   pass_cnt = 0, total_cnt = 0;
  int   next_wait = 0;
  int   mem_issued = 0, rises = 0;
  logic presenting = 1'b0;
  logic err_acc = 1'b0;
  logic retire_pend = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [18:0] ref_rd(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : 19'd0;
  endfunction

  function automatic logic [18:0] resp_rd(input int a);
    return resp_mem.exists(a) ? resp_mem[a] : 19'd0;
  endfunction

  task automatic nop_inputs();
    RegWriteM = 0; MemWriteM = 0; ResultSrcM = 0; Cant_ByteM = 0;
    RDM = '0; WriteDataM = '0; ALUResultM = '0;
  endtask

  // wt: wait cycles before ack; negative means the memory never acks
  task automatic issue(input logic rw, input logic mw, input logic rs, input logic [4:0] rd,
                       input logic [18:0] wd, input logic [18:0] alu, input logic byt,
                       input int wt);
    wexp_t e;
    req_t r;
    logic acc;
    logic [18:0] w;
    int exp_st, st, g;
    acc = mw | (rs & rw);
    next_wait = wt;
    RegWriteM = rw; MemWriteM = mw; ResultSrcM = rs; RDM = rd;
    WriteDataM = wd; ALUResultM = alu; Cant_ByteM = byt;
    presenting = 1'b1;
    e.rw = rw; e.rs = rs; e.rd = rd; e.alu = alu; e.rdata = '0;
    exp_st = 0;
    if (acc) begin
      r.we = mw; r.bm = byt & mw; r.addr = alu; r.wdata = wd;
      req_q.push_back(r);
      mem_issued++;
      if (wt < 0) err_acc = 1'b1;
      else if (mw) begin
        w = ref_rd(int'(alu));
        if (byt) w[7:0] = wd[7:0];
        else     w = wd;
        ref_mem[int'(alu)] = w;
      end else begin
        w = ref_rd(int'(alu));
        e.rdata = byt ? {11'b0, w[7:0]} : w;
      end
      exp_st = (wt < 0) ? TMO + 1 : wt + 1;
    end
    e.err = err_acc;
    exp_q.push_back(e);
    st = 0; g = 0;
    @(negedge clk);
    while (StallM && g < 50) begin
      st++; g++;
      @(negedge clk);
    end
    chk("stall_cycles", st, exp_st);
    @(posedge clk); #1;
    nop_inputs();
    presenting = 1'b0;
  endtask

  task automatic issue_rand();
    int cls;
    logic rw, rs;
    cls = $urandom_range(0, 2);
    if (cls == 0) begin
      rw = 1'($urandom_range(0, 1));
      rs = rw ? 1'b0 : 1'($urandom_range(0, 1));
      issue(rw, 1'b0, rs, 5'($urandom), 19'($urandom), 19'($urandom), 1'($urandom_range(0, 1)), 0);
    end else if (cls == 1) begin
      issue(1'b1, 1'b0, 1'b1, 5'($urandom), 19'($urandom), 19'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end else begin
      issue(1'($urandom_range(0, 1)), 1'b1, 1'b0, 5'($urandom), 19'($urandom),
            19'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end
  endtask

  always @(posedge mif.mem_req) rises++;

  // Memory responder: checks each request, then acks after the chosen number of wait cycles.
  initial begin
    req_t r;
    logic [18:0] w;
    int wt, g;
    mif.mem_ack = 1'b0;
    mif.mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      mif.mem_ack = 1'b0;
      if (mif.mem_req) begin
        if (req_q.size() == 0) begin
          total_cnt++;
          $display("FAIL req_unexpected: got a request with none outstanding at %0t", $time);
        end else begin
          r = req_q.pop_front();
          chk("req_we", mif.mem_we, r.we);
          chk("req_addr", mif.mem_addr, r.addr);
          chk("req_wdata", mif.mem_wdata, r.wdata);
          chk("req_bytemask", mif.mem_bytemask, r.bm);
        end
        wt = next_wait;
        if (wt < 0) begin
          g = 0;
          while (mif.mem_req && g < 300) begin
            @(posedge clk); #1;
            g++;
          end
        end else begin
          for (int i = 0; i < wt; i++) begin
            @(posedge clk); #1;
          end
          if (mif.mem_req) begin
            if (mif.mem_we) begin
              w = resp_rd(int'(mif.mem_addr));
              if (mif.mem_bytemask) w[7:0] = mif.mem_wdata[7:0];
              else                  w = mif.mem_wdata;
              resp_mem[int'(mif.mem_addr)] = w;
              mif.mem_rdata = 19'($urandom);
            end else begin
              mif.mem_rdata = resp_rd(int'(mif.mem_addr));
            end
            mif.mem_ack = 1'b1;
            @(posedge clk); #1;
            mif.mem_ack = 1'b0;
            mif.mem_rdata = 19'($urandom);
          end
        end
      end else if ($urandom_range(0, 3) == 0) begin
        mif.mem_ack = 1'b1;
        mif.mem_rdata = 19'($urandom);
      end
    end
  end

  // Monitor: a retirement edge is followed by a W-register compare; stalled edges must show bubbles.
  always @(negedge clk) begin
    wexp_t e;
    if (reset) retire_pend = 1'b0;
    else begin
      if (retire_pend) begin
        if (exp_q.size() == 0) begin
          total_cnt++;
          $display("FAIL w_unexpected: retirement with empty scoreboard at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          chk("w_regwrite", RegWriteW, e.rw);
          chk("w_resultsrc", ResultSrcW, e.rs);
          chk("w_rd", RDW, e.rd);
          chk("w_aluresult", ALUResultW, e.alu);
          chk("w_readdata", ReadDataW, e.rdata);
          chk("w_mem_err", mem_err, e.err);
        end
      end else if (presenting) begin
        chk("bubble", {RegWriteW, ResultSrcW, RDW}, '0);
      end
      retire_pend = presenting && !StallM;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    nop_inputs();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_req", mif.mem_req, 0);
    chk("rst_stall", StallM, 0);
    chk("rst_mem_err", mem_err, 0);
    chk("rst_w", {RegWriteW, ResultSrcW, RDW, ALUResultW, ReadDataW}, '0);

    ref_mem[32'h40] = 19'h7ABCD; resp_mem[32'h40] = 19'h7ABCD;
    ref_mem[32'h50] = 19'h7FF9C; resp_mem[32'h50] = 19'h7FF9C;
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;

    issue(1, 0, 0, 5'd5, 19'h0, 19'h01234, 0, 0);            // ALU only
    issue(1, 0, 1, 5'd7, 19'h11111, 19'h00040, 0, 3);        // word load, 3 waits
    issue(1, 0, 1, 5'd8, 19'h0, 19'h00050, 1, 1);            // byte load
    issue(0, 1, 0, 5'd0, 19'h12345, 19'h00060, 1, 1);        // byte store
    issue(1, 0, 1, 5'd9, 19'h0, 19'h00060, 0, 0);            // word load sees only the byte
    issue(1, 0, 1, 5'd10, 19'h0, 19'h00040, 0, 0);           // back-to-back loads
    issue(1, 0, 1, 5'd11, 19'h0, 19'h00050, 1, 0);

    for (int n = 0; n < 80; n++) issue_rand();

    issue(1, 0, 1, 5'd12, 19'h0, 19'h00003, 0, -1);          // never acked: timeout
    for (int n = 0; n < 10; n++) issue_rand();

    // Reset in the middle of a pending access
    RegWriteM = 1; ResultSrcM = 1; MemWriteM = 0; RDM = 5'd13;
    ALUResultM = 19'h00004; WriteDataM = '0; Cant_ByteM = 0;
    presenting = 1'b1;
    next_wait = -1;
    begin
      req_t r;
      r.we = 0; r.bm = 0; r.addr = 19'h00004; r.wdata = '0;
      req_q.push_back(r);
    end
    mem_issued++;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midrst_mem_req", mif.mem_req, 0);
    chk("midrst_stall", StallM, 0);
    chk("midrst_mem_err", mem_err, 0);
    chk("midrst_w", {RegWriteW, ResultSrcW, RDW, ALUResultW, ReadDataW}, '0);
    presenting = 1'b0;
    nop_inputs();
    err_acc = 1'b0;
    exp_q.delete();
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;

    for (int n = 0; n < 15; n++) issue_rand();

    repeat (3) @(posedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("req_queue_drained", req_q.size(), 0);
    chk("req_pulses", rises, mem_issued);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/memory_stage.md
# memory_stage

Memory (M) stage of the 19-bit pipelined processor, directly downstream of the Execute stage. It takes the Execute pipeline-register outputs, performs the load or store through a req/ack data-memory port, and emits a stall to the hazard unit while an access is pending. It then loads the M/W pipeline register that feeds Writeback; a timeout watchdog protects against a memory port that never acknowledges.

## Interface
Parameters:
- ADDR_W, 19: data-memory address width; mem_addr = ALUResultM[ADDR_W-1:0].
- TIMEOUT, 255: maximum BUSY cycles without mem_ack before abort; range 1..255.

Ports:
- clk  in  1  stage clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- RegWriteM  in  1  register-write enable from Execute.
- MemWriteM  in  1  store request from Execute.
- ResultSrcM  in  1  1 = load result selected for writeback.
- RDM  in  5  destination register.
- WriteDataM  in  19  store data.
- ALUResultM  in  19  effective address / ALU result.
- Cant_ByteM  in  1  1 = byte access (bits [7:0]), 0 = full 19-bit word.
- mem_req  out  1  memory request, registered.
- mem_we  out  1  1 = write, 0 = read, registered.
- mem_addr  out  ADDR_W  access address, registered.
- mem_wdata  out  19  store data, registered.
- mem_bytemask  out  1  1 = write only bits [7:0], registered.
- mem_rdata  in  19  read data, valid in the mem_ack cycle.
- mem_ack  in  1  one-cycle completion pulse.
- StallM  out  1  combinational; freezes PC, F/D and D/E/E/M registers upstream.
- mem_err  out  1  sticky timeout flag; cleared only by reset.
- RegWriteW, ResultSrcW  out  1 each  M/W register.
- RDW  out  5  M/W register.
- ALUResultW, ReadDataW  out  19 each  M/W register.

## Operation
- Access condition: acc = MemWriteM | (ResultSrcM & RegWriteM).
- FSM states: IDLE, BUSY.
- IDLE, acc=0:
  - StallM=0.
  - M/W register loads the M inputs; ReadDataW loads 0.
- IDLE, acc=1:
  - StallM=1.
  - Next edge: go to BUSY; mem_req<=1, mem_we<=MemWriteM, mem_addr, mem_wdata<=WriteDataM, mem_bytemask<=Cant_ByteM & MemWriteM.
  - Latch RegWriteM, ResultSrcM, RDM, ALUResultM, Cant_ByteM internally; clear the watchdog counter.
  - M/W register loads a bubble: RegWriteW=0, ResultSrcW=0, RDW=0.
- BUSY, mem_ack=0:
  - StallM=1; counter increments; M/W register loads a bubble.
  - When the counter reaches TIMEOUT: treat the cycle as an ack with rdata=0 and set mem_err<=1.
- BUSY, mem_ack=1 (or timeout):
  - StallM=0.
  - Next edge: mem_req<=0, go to IDLE.
  - M/W register loads the latched control and ALUResult.
  - ReadDataW <= latched byte ? {11'b0, mem_rdata[7:0]} : mem_rdata (0 on timeout); zero-extension, no sign-extension.
  - The next instruction enters M on the same edge, so the access is never reissued.
- mem_ack while IDLE is ignored.
- Stores also pass RegWriteM through unchanged.
- Reset at any point (including mid-BUSY):
  - FSM to IDLE; mem_req, mem_we, mem_addr, mem_wdata and mem_bytemask to 0.
  - mem_err=0; counter=0.
  - All W outputs 0.
  - The pending access is dropped; the memory must discard it.

## Timing
- Minimum M occupancy for a memory instruction: 2 cycles (detect cycle + ack in the first BUSY cycle); each extra wait cycle adds 1.
- Non-memory instructions: 1 cycle, no stall.
- mem_req rises the edge after detection and stays high continuously until the edge after mem_ack.
- mem_addr, mem_wdata and mem_we are stable while mem_req=1.
- StallM is combinational from state, acc and mem_ack; it is never asserted in the ack cycle.
- ReadDataW/ALUResultW are valid the cycle after the ack.
- Back-to-back accesses: the instruction after an acked access is detected in IDLE on the cycle after the ack, giving one idle cycle with mem_req=0 between accesses.
- Timeout: abort occurs in the BUSY cycle where counter==TIMEOUT, i.e. TIMEOUT+1 BUSY cycles in total.

## Test plan
- Reset check: hold reset high mid-BUSY -> mem_req=0, StallM=0, all W outputs 0, mem_err=0 immediately (asynchronous).
- ALU-only instruction (RegWriteM=1, RDM=5, ALUResultM=0x1234, ResultSrcM=0) -> no stall; next cycle RegWriteW=1, RDW=5, ALUResultW=0x1234.
- Word load, addr 0x00040, ack after 3 wait cycles with rdata=0x7ABCD:
  - StallM high for 4 cycles.
  - ReadDataW=0x7ABCD, ResultSrcW=1.
  - Bubbles (RegWriteW=0) while stalled.
- Byte load, mem_rdata=0x7FF9C -> ReadDataW=0x0009C.
- Byte store, WriteDataM=0x12345 -> mem_we=1, mem_bytemask=1, mem_wdata=0x12345; no W-side load data (ReadDataW=0).
- Two back-to-back loads with immediate ack:
  - Exactly one mem_req pulse per load.
  - Each load's W data is correct.
- No ack for TIMEOUT=4 -> abort after 5 BUSY cycles, mem_err=1 and stays high, ReadDataW=0, pipeline resumes.
